// File: rtl/blink_pkg.sv
// ============================================================================
// Module      : blink_pkg
// Description : Mode encodings and LED entry values shared by the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_DUAL = 2'b01,
        MODE_SLOW = 2'b10,
        MODE_ALT  = 2'b11
    } mode_e;

    localparam logic [1:0] LED_ALT_ENTRY = 2'b01;
    localparam logic [1:0] LED_DARK      = 2'b00;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_OFF:  return MODE_DUAL;
            MODE_DUAL: return MODE_SLOW;
            MODE_SLOW: return MODE_ALT;
            default:   return MODE_OFF;
        endcase
    endfunction

    function automatic logic [1:0] entry_led(input mode_e m);
        return (m == MODE_ALT) ? LED_ALT_ENTRY : LED_DARK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchronizer, debounce counter and rising-edge press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int unsigned DEBOUNCE_MAX = 120000 - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_stable,
    output logic press
);

    localparam int DB_WIDTH = (DEBOUNCE_MAX > 0) ? $clog2(DEBOUNCE_MAX + 1) : 1;
    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_MAX);

    logic [1:0]          sync_q,   sync_d;
    logic                stable_q, stable_d;
    logic [DB_WIDTH-1:0] db_cnt_q, db_cnt_d;
    logic                w_btn_sync;
    logic                w_db_done;

    // press is combinational so the consumer acts on the same edge that
    // btn_stable rises.
    always_comb begin
        sync_d     = {sync_q[0], btn_in};
        w_btn_sync = sync_q[1];
        w_db_done  = (w_btn_sync != stable_q) && (db_cnt_q == DB_LAST);
        stable_d   = w_db_done ? w_btn_sync : stable_q;
        db_cnt_d   = db_cnt_q + 1'b1;
        if ((w_btn_sync == stable_q) || w_db_done) begin
            db_cnt_d = '0;
        end
        press = w_db_done && w_btn_sync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign btn_stable = stable_q;

endmodule

`default_nettype wire

// File: rtl/blink_scheduler.sv
// ============================================================================
// Module      : blink_scheduler
// Description : Button-selected LED blink patterns driven by a prescaled tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_scheduler
    import blink_pkg::*;
#(
    parameter int          COUNT_WIDTH  = 32,
    parameter int unsigned TICK_MAX     = 1500000 - 1,
    parameter int unsigned DEBOUNCE_MAX = 120000 - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    output logic [1:0] led,
    output logic [1:0] mode
);

    localparam logic [COUNT_WIDTH-1:0] TICK_LAST = COUNT_WIDTH'(TICK_MAX);

    logic [COUNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic [1:0]             phase_q, phase_d;
    mode_e                  mode_q,  mode_d;
    logic [1:0]             led_q,   led_d;
    logic                   w_tick;
    logic                   w_slow;
    logic                   w_press;
    logic                   w_btn_stable;

    button_debouncer #(
        .DEBOUNCE_MAX (DEBOUNCE_MAX)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_mode),
        .btn_stable (w_btn_stable),
        .press      (w_press)
    );

    always_comb begin
        w_tick  = (cnt_q == TICK_LAST);
        w_slow  = w_tick && (phase_q == 2'd3);
        cnt_d   = w_tick ? '0 : cnt_q + 1'b1;
        phase_d = w_tick ? phase_q + 2'd1 : phase_q;
        mode_d  = mode_q;
        led_d   = led_q;

        // A press restarts the timebase, so a coincident tick never toggles.
        if (w_press) begin
            cnt_d   = '0;
            phase_d = 2'd0;
            mode_d  = next_mode(mode_q);
            led_d   = entry_led(next_mode(mode_q));
        end else begin
            case (mode_q)
                MODE_OFF: led_d = LED_DARK;
                MODE_DUAL: begin
                    if (w_tick) led_d[0] = ~led_q[0];
                    if (w_slow) led_d[1] = ~led_q[1];
                end
                default: begin
                    if (w_slow) led_d = ~led_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 2'd0;
            mode_q  <= MODE_OFF;
            led_q   <= LED_DARK;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
        end
    end

    // The press edge is the one where btn_stable is still low.
    a_press_on_rise: assert property (@(posedge clk) disable iff (rst)
                                      w_press |-> !w_btn_stable);

    assign led  = led_q;
    assign mode = mode_q;

endmodule

`default_nettype wire

// File: doc/blink_scheduler.md
BLINK_SCHEDULER -- requirements
Module: blink_scheduler

Interface
REQ-001 The block SHALL have parameter COUNT_WIDTH, default 32, setting the prescaler counter width in bits.
REQ-002 The block SHALL have parameter TICK_MAX, default 1500000-1, the prescaler terminal count; this gives a 125 ms base tick at 12 MHz.
REQ-003 The block SHALL have parameter DEBOUNCE_MAX, default 120000-1, the debounce terminal count; this gives 10 ms at 12 MHz.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port btn_mode, input, 1 bit: raw active-high mode pushbutton, asynchronous to clk.
REQ-007 The block SHALL have port led, output, 2 bits: registered LED drive.
REQ-008 The block SHALL have port mode, output, 2 bits: current mode, registered.

Function
REQ-009 The prescaler SHALL count 0..TICK_MAX and wrap to 0; tick SHALL be high for the one cycle in which count equals TICK_MAX.
REQ-010 A 2-bit phase counter SHALL increment on each tick and wrap from 3 to 0; a slow event is a tick while phase equals 3.
REQ-011 Modes and per-mode LED behaviour SHALL be as follows:
- OFF=00: led held at 00.
- DUAL=01: led[0] toggles on every tick (4 Hz); led[1] toggles on every slow event (1 Hz).
- SLOW=10: both LEDs toggle together on every slow event.
- ALT=11: led toggles on every slow event, with led[1] always equal to ~led[0].
REQ-012 The mode FSM SHALL advance OFF->DUAL->SLOW->ALT->OFF, one step per debounced press, and SHALL have no other transitions.
REQ-013 The button SHALL pass through a 2-flop synchronizer to produce btn_sync.
REQ-014 The debounce counter SHALL increment each cycle in which btn_sync != btn_stable, and SHALL clear in any cycle where they are equal.
REQ-015 At the edge where the debounce counter equals DEBOUNCE_MAX and btn_sync still differs, btn_stable SHALL take the value of btn_sync and the counter SHALL clear.
REQ-016 A press SHALL be the edge at which btn_stable goes 0->1; mode SHALL update on that same edge.
REQ-017 Press latency SHALL be exact: with btn_mode first sampled high at edge 1, mode updates at edge DEBOUNCE_MAX+3.
REQ-018 Any btn_sync pulse shorter than DEBOUNCE_MAX+1 cycles SHALL be ignored.
REQ-019 A held button SHALL produce exactly one press, and release SHALL produce none.
REQ-020 On the press edge, the prescaler and phase counter SHALL clear to 0.
REQ-021 On the press edge, led SHALL load the entry value of the new mode: 00 for OFF, DUAL and SLOW; 01 for ALT.
REQ-022 If a press and a tick coincide, the press SHALL win and the tick SHALL be discarded, with no toggle.
REQ-023 All arithmetic SHALL be unsigned with modulo wrap, and TICK_MAX SHALL fit in COUNT_WIDTH.

Reset
REQ-024 While rst is high at a clock edge, the block SHALL clear to: prescaler 0, phase 0, debounce counter 0, sync flops 0, btn_stable 0, mode OFF, led 00.
REQ-025 Reset SHALL take priority over presses and ticks, including reset asserted mid-debounce or mid-blink.
REQ-026 A button held through reset release SHALL register as one press after DEBOUNCE_MAX+3 edges.

Structure
REQ-027 Shared package blink_pkg SHALL hold the mode encodings (MODE_OFF, MODE_DUAL, MODE_SLOW, MODE_ALT) and the ALT entry LED value.
REQ-028 Sub-module button_debouncer SHALL contain the synchronizer, the debounce counter and the rise pulse.
REQ-029 button_debouncer SHALL have parameter DEBOUNCE_MAX and ports clk, rst, btn_in, btn_stable, press.
REQ-030 The prescaler, phase counter, mode FSM and LED logic SHALL reside in blink_scheduler.

Verification
REQ-031 Every bench SHALL run with TICK_MAX=3 (a tick every 4 cycles) and DEBOUNCE_MAX=3.
REQ-032 Reset scenario: hold rst high for 2 cycles, then idle 40 cycles -> led=00 and mode=00 throughout.
REQ-033 Single-press scenario: raise btn_mode at edge 1 and hold it 10 cycles -> mode=01 at edge 6.
REQ-034 The single-press scenario SHALL also check: led[0] toggles every 4 cycles from then on, and led[1] toggles every 16 cycles.
REQ-035 Glitch scenario: btn_mode high for 3 cycles -> mode and led unchanged.
REQ-036 Mode-cycle scenario: four separated presses -> mode reads 01, 10, 11, 00.
REQ-037 In ALT within the mode-cycle scenario, led=01 on entry and 10 after 16 cycles; after the fourth press, led=00.
REQ-038 Hold scenario: btn_mode held 100 cycles, then released -> exactly one advance, and no advance on release.
REQ-039 Reset-mid-operation scenario: in ALT with led=10, pulse rst for 1 cycle -> led=00 and mode=00 at the next edge, and the counters restart from 0.
